// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the ID/EX pipeline register and the EX stage.
// The pipeline register takes the slave side; the surrounding core (or a bench) takes the master side.
interface id_ex_stage_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       id_pcsrc, id_regdst, id_mem2reg;
    logic             id_branch, id_regwrite, id_memread, id_memwrite;
    logic             id_alusrc1, id_alusrc2, id_jump;
    logic [3:0]       id_aluop;
    logic [4:0]       id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]       id_funct;
    logic [31:0]      id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic             ex_branch_taken;

    logic [1:0]       ex_pcsrc, ex_regdst, ex_mem2reg;
    logic             ex_branch, ex_regwrite, ex_memread, ex_memwrite;
    logic             ex_alusrc1, ex_alusrc2, ex_jump;
    logic [3:0]       ex_aluop;
    logic [4:0]       ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
    logic [5:0]       ex_funct;
    logic [31:0]      ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic             stall_o, flush_ifid_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output id_pcsrc, id_regdst, id_mem2reg, id_branch, id_regwrite, id_memread,
               id_memwrite, id_alusrc1, id_alusrc2, id_jump, id_aluop, id_rs, id_rt,
               id_rd, id_shamt, id_funct, id_rs_data, id_rt_data, id_imm, id_pc_plus4,
               ex_branch_taken,
        input  ex_pcsrc, ex_regdst, ex_mem2reg, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_jump, ex_aluop, ex_rs, ex_rt,
               ex_rd, ex_shamt, ex_funct, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               ex_wreg, stall_o, flush_ifid_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_pcsrc, id_regdst, id_mem2reg, id_branch, id_regwrite, id_memread,
               id_memwrite, id_alusrc1, id_alusrc2, id_jump, id_aluop, id_rs, id_rt,
               id_rd, id_shamt, id_funct, id_rs_data, id_rt_data, id_imm, id_pc_plus4,
               ex_branch_taken,
        output ex_pcsrc, ex_regdst, ex_mem2reg, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_jump, ex_aluop, ex_rs, ex_rt,
               ex_rd, ex_shamt, ex_funct, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               ex_wreg, stall_o, flush_ifid_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the MIPS core: load-use stall, bubble insertion,
// branch squash, jump flush of IF/ID and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_pcsrc, r_regdst, r_mem2reg;
    logic             r_branch, r_regwrite, r_memread, r_memwrite;
    logic             r_alusrc1, r_alusrc2, r_jump;
    logic [3:0]       r_aluop;
    logic [4:0]       r_rs, r_rt, r_rd, r_shamt, r_wreg;
    logic [5:0]       r_funct;
    logic [31:0]      r_rs_data, r_rt_data, r_imm, r_pc_plus4;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic             w_load_use, w_stall, w_flush, w_bubble;
    logic [4:0]       w_wreg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    always_comb begin
        w_wreg = 5'd0;
        case (bus.id_regdst)
            2'b00:   w_wreg = bus.id_rt;
            2'b01:   w_wreg = bus.id_rd;
            2'b10:   w_wreg = 5'd31;
            default: w_wreg = 5'd0;
        endcase
    end

    // rs and rt are compared unconditionally; a spurious stall for an rt-less instruction is tolerated.
    assign w_load_use = r_memread & r_regwrite & (r_wreg != 5'd0) &
                        ((r_wreg == bus.id_rs) | (r_wreg == bus.id_rt));
    assign w_stall    = ~bus.ex_branch_taken & w_load_use;
    assign w_flush    = bus.ex_branch_taken | (~w_load_use & bus.id_jump);
    assign w_bubble   = bus.ex_branch_taken | w_load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcsrc    <= '0;
            r_regdst   <= '0;
            r_mem2reg  <= '0;
            r_branch   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc1  <= 1'b0;
            r_alusrc2  <= 1'b0;
            r_jump     <= 1'b0;
            r_aluop    <= '0;
            r_wreg     <= '0;
        end else if (w_bubble) begin
            r_pcsrc    <= '0;
            r_regdst   <= '0;
            r_mem2reg  <= '0;
            r_branch   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc1  <= 1'b0;
            r_alusrc2  <= 1'b0;
            r_jump     <= 1'b0;
            r_aluop    <= '0;
            r_wreg     <= '0;
        end else begin
            r_pcsrc    <= bus.id_pcsrc;
            r_regdst   <= bus.id_regdst;
            r_mem2reg  <= bus.id_mem2reg;
            r_branch   <= bus.id_branch;
            r_regwrite <= bus.id_regwrite;
            r_memread  <= bus.id_memread;
            r_memwrite <= bus.id_memwrite;
            r_alusrc1  <= bus.id_alusrc1;
            r_alusrc2  <= bus.id_alusrc2;
            r_jump     <= bus.id_jump;
            r_aluop    <= bus.id_aluop;
            r_wreg     <= w_wreg;
        end
    end

    // Data fields load every cycle, bubble or not; only the control word is squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_funct    <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_pc_plus4 <= '0;
        end else begin
            r_rs       <= bus.id_rs;
            r_rt       <= bus.id_rt;
            r_rd       <= bus.id_rd;
            r_shamt    <= bus.id_shamt;
            r_funct    <= bus.id_funct;
            r_rs_data  <= bus.id_rs_data;
            r_rt_data  <= bus.id_rt_data;
            r_imm      <= bus.id_imm;
            r_pc_plus4 <= bus.id_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign bus.ex_pcsrc     = r_pcsrc;
    assign bus.ex_regdst    = r_regdst;
    assign bus.ex_mem2reg   = r_mem2reg;
    assign bus.ex_branch    = r_branch;
    assign bus.ex_regwrite  = r_regwrite;
    assign bus.ex_memread   = r_memread;
    assign bus.ex_memwrite  = r_memwrite;
    assign bus.ex_alusrc1   = r_alusrc1;
    assign bus.ex_alusrc2   = r_alusrc2;
    assign bus.ex_jump      = r_jump;
    assign bus.ex_aluop     = r_aluop;
    assign bus.ex_rs        = r_rs;
    assign bus.ex_rt        = r_rt;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_shamt     = r_shamt;
    assign bus.ex_funct     = r_funct;
    assign bus.ex_rs_data   = r_rs_data;
    assign bus.ex_rt_data   = r_rt_data;
    assign bus.ex_imm       = r_imm;
    assign bus.ex_pc_plus4  = r_pc_plus4;
    assign bus.ex_wreg      = r_wreg;
    assign bus.stall_o      = w_stall;
    assign bus.flush_ifid_o = w_flush;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS core. Captures the decoded control word, register operands and immediate from the ID stage and presents them, registered, to EX. Owns hazard handling between ID and EX:
- load-use stall detection;
- bubble insertion;
- squash on a taken branch resolved in EX;
- IF/ID flush on jumps decoded in ID;
- saturating stall/flush event counters for performance monitoring.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_pcsrc, id_regdst, id_mem2reg  in  2 each  decoder control fields
- id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2, id_jump  in  1 each  decoder control bits
- id_aluop  in  4  decoder ALUOp
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_funct  in  6  instruction funct field
- id_rs_data, id_rt_data, id_imm, id_pc_plus4  in  32 each  register-file operands, extended immediate, PC+4
- ex_branch_taken  in  1  branch condition true for the instruction currently in EX
- ex_* (one per id_* input above)  out  same widths  registered copies of the id_* inputs
- ex_wreg  out  5  registered destination register: RegDst 00→rt, 01→rd, 10→31, 11→0
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_ifid_o  out  1  replace the IF/ID contents with a bubble at the next edge
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- **Bubble:** all ex_* control outputs (pcsrc, branch, regwrite, regdst, memread, memwrite, mem2reg, alusrc1/2, aluop, jump) and ex_wreg = 0. Data fields (ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4, ex_rs/rt/rd/shamt/funct) are don't-care but load the id_* values.
- **Load-use:**
  - load_use = ex_memread & ex_regwrite & (ex_wreg != 0) & ((ex_wreg == id_rs) | (ex_wreg == id_rt)).
  - rs and rt are compared unconditionally. A false stall on an instruction that does not read rt is accepted behaviour.
- **Priority:** ex_branch_taken first, then load_use, then normal operation.
- **ex_branch_taken = 1:**
  - stall_o = 0.
  - flush_ifid_o = 1.
  - Next edge loads a bubble into ID/EX.
  - flush_cnt increments by 1.
  - This overrides both load_use and id_jump.
- **load_use = 1 (no taken branch):**
  - stall_o = 1.
  - flush_ifid_o = 0, even if id_jump = 1. The jump re-presents next cycle.
  - Next edge loads a bubble into ID/EX.
  - stall_cnt increments by 1.
- **Otherwise:**
  - Next edge loads the id_* inputs into ID/EX.
  - flush_ifid_o = id_jump.
  - If id_jump = 1, flush_cnt increments by 1.
- **Stall length:** a load-use stall lasts exactly one cycle. After the bubble, EX no longer holds the load, so load_use deasserts.
- **Counters:** saturate at 2^CNT_W−1 and never wrap.

## Timing
- stall_o and flush_ifid_o are combinational from the current id_*, ex_* and ex_branch_taken. There are no registers on these paths.
- ex_* outputs are registered with 1-cycle latency from id_* (ID at edge n → EX after edge n).
- **On reset assertion (any time, asynchronous):**
  - All ex_* outputs, ex_wreg, stall_cnt and flush_cnt go to 0 immediately.
  - EX therefore holds a bubble, so stall_o = 0, and flush_ifid_o = id_jump.
- **Reset mid-stall:** the pending bubble is irrelevant. The state after deassertion is the reset state.
- **Reset release:** the first rising edge after deassertion loads id_* normally.
- **Counter increments:** both counters update on the same edge that loads ID/EX. Both can never increment in one cycle, because branch overrides stall.

## Test plan
- **Pass-through:** id_regwrite=1, id_regdst=01, id_rd=5, id_rs_data=32'h1234 → after 1 edge: ex_regwrite=1, ex_wreg=5, ex_rs_data=32'h1234; stall_o=0; counters=0.
- **Load-use:** lw into $8 in EX (ex_memread=1, ex_wreg=8), ID has id_rs=8 → stall_o=1 for exactly one cycle; next EX is a bubble (ex_regwrite=0, ex_memread=0); stall_cnt=1; the following edge loads the held instruction. Repeat with ex_wreg=0 → no stall.
- **Branch squash:** ex_branch_taken=1 while load_use and id_jump are both true → stall_o=0, flush_ifid_o=1, next EX is a bubble, flush_cnt=1, stall_cnt unchanged.
- **Jump vs stall:** id_jump=1 with load_use → flush_ifid_o=0 and stall_o=1. Next cycle (no hazard) → flush_ifid_o=1 and the jump enters EX with ex_jump=1, ex_pcsrc=01.
- **Jal destination:** id_regdst=10, id_regwrite=1 → ex_wreg=31.
- **Reset and saturation:**
  - Assert reset between edges mid-stall → all outputs 0 immediately, without waiting for a clock edge.
  - With CNT_W=2, four load-use events → stall_cnt holds at 3.
